// File: rtl/simd_ctrl_pkg.sv
// Shared types and branch encodings for the SIMD execute-stage controller.
package simd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [2:0] BR_NZ = 3'b100;
    localparam logic [2:0] BR_Z  = 3'b010;
    localparam logic [2:0] BR_N  = 3'b001;

    // Any code other than the three one-hot patterns resolves to not-taken.
    function automatic logic branch_taken(input logic [2:0] br, input logic n, input logic z);
        logic taken;
        taken = 1'b0;
        case (br)
            BR_NZ:   taken = ~z;
            BR_Z:    taken = z;
            BR_N:    taken = n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Decode request, lane-array and flag/branch signals of the execute sequencer.
interface exec_sequencer_if #(
    parameter int laneCount = 2,
    parameter int idxW      = 2
);
    logic                 reqValid;
    logic                 reqReady;
    logic [2:0]           reqOp;
    logic [2:0]           reqBranch;
    logic                 reqSetFlags;
    logic [2:0]           aluOp;
    logic [idxW-1:0]      chunkIdx;
    logic                 chunkValid;
    logic [laneCount-1:0] laneNeg;
    logic [laneCount-1:0] laneZero;
    logic                 done;
    logic                 pcWrEnOut;
    logic                 flagN;
    logic                 flagZ;
    logic                 busy;

    modport master (
        output reqValid, reqOp, reqBranch, reqSetFlags, laneNeg, laneZero,
        input  reqReady, aluOp, chunkIdx, chunkValid, done, pcWrEnOut, flagN, flagZ, busy
    );

    modport slave (
        input  reqValid, reqOp, reqBranch, reqSetFlags, laneNeg, laneZero,
        output reqReady, aluOp, chunkIdx, chunkValid, done, pcWrEnOut, flagN, flagZ, busy
    );
endinterface

// File: rtl/nz_flag_accum.sv
// Accumulates per-lane N/Z across chunks and holds the architectural N/Z flags.
// Latency: flags load on the final-chunk edge, including that chunk's lanes.
// Backpressure: none; enables come from the sequencer FSM.
module nz_flag_accum #(
    parameter int laneCount = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 acc_en_i,
    input  logic                 load_i,
    input  logic [laneCount-1:0] lane_neg_i,
    input  logic [laneCount-1:0] lane_zero_i,
    output logic                 flag_n_o,
    output logic                 flag_z_o
);
    logic neg_acc_q, neg_acc_d, zero_acc_q, zero_acc_d;
    logic flag_n_q, flag_n_d, flag_z_q, flag_z_d;
    logic neg_nxt, zero_nxt;

    assign neg_nxt  = neg_acc_q | (|lane_neg_i);
    assign zero_nxt = zero_acc_q & (&lane_zero_i);

    always_comb begin
        neg_acc_d  = neg_acc_q;
        zero_acc_d = zero_acc_q;
        flag_n_d   = flag_n_q;
        flag_z_d   = flag_z_q;
        if (clr_i) begin
            neg_acc_d  = 1'b0;
            zero_acc_d = 1'b1;
        end else if (acc_en_i) begin
            neg_acc_d  = neg_nxt;
            zero_acc_d = zero_nxt;
        end
        if (load_i) begin
            flag_n_d = neg_nxt;
            flag_z_d = zero_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_acc_q  <= 1'b0;
            zero_acc_q <= 1'b1;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
        end else begin
            neg_acc_q  <= neg_acc_d;
            zero_acc_q <= zero_acc_d;
            flag_n_q   <= flag_n_d;
            flag_z_q   <= flag_z_d;
        end
    end

    assign flag_n_o = flag_n_q;
    assign flag_z_o = flag_z_q;
endmodule

// File: rtl/exec_sequencer.sv
// Sequences one vector op through laneCount ALU lanes, chunk by chunk, then resolves the branch.
// Latency: chunk k on lanes at t0+1+k, done at t0+1+numChunks after accept edge t0.
// Backpressure: reqReady low during RUN; a request waiting in DONE is taken back-to-back.
module exec_sequencer
    import simd_ctrl_pkg::*;
#(
    parameter int regSize   = 16,
    parameter int vecSize   = 8,
    parameter int laneCount = 2
) (
    input  logic clk,
    input  logic rst,
    exec_sequencer_if.slave bus
);
    localparam int numChunks = vecSize / laneCount;
    localparam int idxW      = (numChunks > 1) ? $clog2(numChunks) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    if (regSize < 1 || (vecSize % laneCount) != 0) begin : g_param_check
        $error("exec_sequencer: vecSize must be a multiple of laneCount");
    end

    logic [1:0]      state_q, state_d;
    logic [idxW-1:0] chunk_q, chunk_d;
    logic [2:0]      op_q, op_d, br_q, br_d;
    logic            setf_q, setf_d;
    logic            accept, in_run, in_done, last_chunk;

    assign in_run     = (state_q == S_RUN);
    assign in_done    = (state_q == S_DONE);
    assign last_chunk = (chunk_q == idxW'(numChunks - 1));
    assign accept     = bus.reqValid & bus.reqReady;

    // Accept is only possible from IDLE/DONE, so it safely overrides the state decode.
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        op_d    = op_q;
        br_d    = br_q;
        setf_d  = setf_q;
        case (state_q)
            S_RUN: begin
                if (last_chunk) state_d = S_DONE;
                else            chunk_d = chunk_q + idxW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_RUN;
            chunk_d = '0;
            op_d    = bus.reqOp;
            br_d    = bus.reqBranch;
            setf_d  = bus.reqSetFlags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            chunk_q <= '0;
            op_q    <= 3'b000;
            br_q    <= 3'b000;
            setf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            op_q    <= op_d;
            br_q    <= br_d;
            setf_q  <= setf_d;
        end
    end

    nz_flag_accum #(.laneCount(laneCount)) u_flags (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (accept),
        .acc_en_i    (in_run),
        .load_i      (in_run & last_chunk & setf_q),
        .lane_neg_i  (bus.laneNeg),
        .lane_zero_i (bus.laneZero),
        .flag_n_o    (bus.flagN),
        .flag_z_o    (bus.flagZ)
    );

    assign bus.reqReady   = (state_q == S_IDLE) | in_done;
    assign bus.aluOp      = op_q;
    assign bus.chunkIdx   = chunk_q;
    assign bus.chunkValid = in_run;
    assign bus.done       = in_done;
    assign bus.busy       = in_run | in_done;
    assign bus.pcWrEnOut  = in_done & branch_taken(br_q, bus.flagN, bus.flagZ);
endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized self-checking bench for exec_sequencer (vecSize=8, laneCount=2).
module tb_exec_sequencer;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests_run = 0;
    int tests_failed = 0;

    exec_sequencer_if #(.laneCount(2), .idxW(2)) bus();

    exec_sequencer #(.regSize(16), .vecSize(8), .laneCount(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Lane stimulus per chunk and the reference architectural state.
    logic [1:0] neg_v [NCH];
    logic [1:0] zero_v [NCH];
    logic m_n = 1'b0, m_z = 1'b0, m_pc = 1'b0;

    // Observations captured by drive_op.
    logic [1:0] o_idx [NCH];
    logic       o_vld [NCH];
    logic       o_rdy [NCH];
    logic [2:0] o_op  [NCH];
    logic       o_acc_rdy, o_done, o_pc, o_n, o_z, o_done2, o_busy2;

    task automatic model_op(input logic [2:0] br, input logic sf);
        logic any_neg, all_zero;
        any_neg = 1'b0;
        all_zero = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (neg_v[k] != 2'b00) any_neg = 1'b1;
            if (zero_v[k] != 2'b11) all_zero = 1'b0;
        end
        if (sf) begin
            m_n = any_neg;
            m_z = all_zero;
        end
        if (br == 3'b100)      m_pc = !m_z;
        else if (br == 3'b010) m_pc = m_z;
        else if (br == 3'b001) m_pc = m_n;
        else                   m_pc = 1'b0;
    endtask

    // Starts and ends just after a rising edge, DUT idle on entry.
    task automatic drive_op(input logic [2:0] op, input logic [2:0] br, input logic sf);
        bus.reqValid = 1'b1;
        bus.reqOp = op;
        bus.reqBranch = br;
        bus.reqSetFlags = sf;
        bus.laneNeg = 2'($urandom);
        bus.laneZero = 2'($urandom);
        @(negedge clk); o_acc_rdy = bus.reqReady;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        bus.reqOp = 3'($urandom);
        bus.reqBranch = 3'($urandom);
        bus.reqSetFlags = 1'($urandom);
        for (int k = 0; k < NCH; k++) begin
            bus.laneNeg = neg_v[k];
            bus.laneZero = zero_v[k];
            @(negedge clk);
            o_idx[k] = bus.chunkIdx;
            o_vld[k] = bus.chunkValid;
            o_rdy[k] = bus.reqReady;
            o_op[k] = bus.aluOp;
            @(posedge clk); #1;
        end
        bus.laneNeg = 2'($urandom);
        bus.laneZero = 2'($urandom);
        @(negedge clk);
        o_done = bus.done; o_pc = bus.pcWrEnOut; o_n = bus.flagN; o_z = bus.flagZ;
        @(posedge clk); #1;
        @(negedge clk);
        o_done2 = bus.done; o_busy2 = bus.busy;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.reqValid = 1'b0; bus.reqOp = 3'b000; bus.reqBranch = 3'b000; bus.reqSetFlags = 1'b0;
        bus.laneNeg = 2'b00; bus.laneZero = 2'b00;
        #2;
        tests_run++;
        if ({bus.reqReady, bus.aluOp, bus.chunkIdx, bus.chunkValid, bus.done, bus.pcWrEnOut,
             bus.flagN, bus.flagZ, bus.busy} !== 12'b1_000_00_000000) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%b op=%b idx=%b vld=%b done=%b pc=%b n=%b z=%b busy=%b exp rdy=1 rest 0",
                     bus.reqReady, bus.aluOp, bus.chunkIdx, bus.chunkValid, bus.done, bus.pcWrEnOut, bus.flagN, bus.flagZ, bus.busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.reqReady !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", bus.reqReady, bus.busy);
        end
        m_n = 1'b0; m_z = 1'b0;
    endtask

    task automatic test_zero_branch();
        for (int k = 0; k < NCH; k++) begin neg_v[k] = 2'b00; zero_v[k] = 2'b11; end
        drive_op(3'b011, 3'b010, 1'b1);
        model_op(3'b010, 1'b1);
        tests_run++;
        if (o_acc_rdy !== 1'b1) begin tests_failed++; $display("FAIL zb_accept_ready got=%b exp=1", o_acc_rdy); end
        for (int k = 0; k < NCH; k++) begin
            tests_run++;
            if ({o_idx[k], o_vld[k], o_rdy[k], o_op[k]} !== {2'(k), 1'b1, 1'b0, 3'b011}) begin
                tests_failed++;
                $display("FAIL zb_chunk%0d got idx=%0d vld=%b rdy=%b op=%b exp idx=%0d vld=1 rdy=0 op=011",
                         k, o_idx[k], o_vld[k], o_rdy[k], o_op[k], k);
            end
        end
        tests_run++;
        if ({o_done, o_z, o_pc} !== {1'b1, m_z, m_pc} || m_z !== 1'b1 || m_pc !== 1'b1) begin
            tests_failed++;
            $display("FAIL zb_done got done=%b z=%b pc=%b exp done=1 z=1 pc=1", o_done, o_z, o_pc);
        end
        tests_run++;
        if ({o_done2, o_busy2} !== 2'b00) begin
            tests_failed++;
            $display("FAIL zb_single_pulse got done=%b busy=%b exp 0 0", o_done2, o_busy2);
        end
    endtask

    task automatic test_nz_branch();
        for (int k = 0; k < NCH; k++) begin neg_v[k] = 2'b00; zero_v[k] = (k == 2) ? 2'b01 : 2'b11; end
        drive_op(3'b011, 3'b100, 1'b1);
        model_op(3'b100, 1'b1);
        tests_run++;
        if ({o_done, o_z, o_pc} !== {1'b1, m_z, m_pc}) begin
            tests_failed++;
            $display("FAIL nz_taken got done=%b z=%b pc=%b exp done=1 z=%b pc=%b", o_done, o_z, o_pc, m_z, m_pc);
        end
        drive_op(3'b011, 3'b010, 1'b1);
        model_op(3'b010, 1'b1);
        tests_run++;
        if ({o_done, o_z, o_pc} !== {1'b1, m_z, m_pc}) begin
            tests_failed++;
            $display("FAIL z_not_taken got done=%b z=%b pc=%b exp done=1 z=%b pc=%b", o_done, o_z, o_pc, m_z, m_pc);
        end
    endtask

    task automatic test_hold_flags();
        for (int k = 0; k < NCH; k++) begin neg_v[k] = (k == 1) ? 2'b10 : 2'b00; zero_v[k] = 2'b00; end
        drive_op(3'b101, 3'b000, 1'b1);
        model_op(3'b000, 1'b1);
        tests_run++;
        if ({o_n, o_z, o_pc} !== {m_n, m_z, m_pc}) begin
            tests_failed++;
            $display("FAIL set_neg got n=%b z=%b pc=%b exp n=%b z=%b pc=%b", o_n, o_z, o_pc, m_n, m_z, m_pc);
        end
        for (int k = 0; k < NCH; k++) begin neg_v[k] = 2'b00; zero_v[k] = 2'($urandom); end
        drive_op(3'b110, 3'b001, 1'b0);
        model_op(3'b001, 1'b0);
        tests_run++;
        if ({o_done, o_n, o_z, o_pc} !== {1'b1, m_n, m_z, m_pc}) begin
            tests_failed++;
            $display("FAIL hold_flags got done=%b n=%b z=%b pc=%b exp done=1 n=%b z=%b pc=%b",
                     o_done, o_n, o_z, o_pc, m_n, m_z, m_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic seen;
        bus.reqValid = 1'b1; bus.reqOp = 3'b010; bus.reqBranch = 3'b000; bus.reqSetFlags = 1'b0;
        bus.laneNeg = 2'b11; bus.laneZero = 2'b00;
        @(posedge clk); #1;
        bus.reqOp = 3'b111;
        for (int k = 0; k < NCH; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.reqReady, bus.chunkValid, bus.chunkIdx, bus.aluOp} !== {1'b0, 1'b1, 2'(k), 3'b010}) begin
                tests_failed++;
                $display("FAIL b2b_run%0d got rdy=%b vld=%b idx=%0d op=%b exp rdy=0 vld=1 idx=%0d op=010",
                         k, bus.reqReady, bus.chunkValid, bus.chunkIdx, bus.aluOp, k);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests_run++;
        if ({bus.done, bus.reqReady, bus.aluOp} !== {1'b1, 1'b1, 3'b010}) begin
            tests_failed++;
            $display("FAIL b2b_done got done=%b rdy=%b op=%b exp 1 1 010", bus.done, bus.reqReady, bus.aluOp);
        end
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.chunkIdx, bus.chunkValid, bus.done, bus.aluOp} !== {2'd0, 1'b1, 1'b0, 3'b111}) begin
            tests_failed++;
            $display("FAIL b2b_second got idx=%0d vld=%b done=%b op=%b exp 0 1 0 111",
                     bus.chunkIdx, bus.chunkValid, bus.done, bus.aluOp);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || {bus.flagN, bus.flagZ} !== {m_n, m_z}) begin
            tests_failed++;
            $display("FAIL b2b_second_done got seen=%b n=%b z=%b exp seen=1 n=%b z=%b", seen, bus.flagN, bus.flagZ, m_n, m_z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int pulses;
        bus.reqValid = 1'b1; bus.reqOp = 3'b001; bus.reqBranch = 3'b001; bus.reqSetFlags = 1'b1;
        bus.laneNeg = 2'b11; bus.laneZero = 2'b11;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if ({bus.chunkIdx, bus.chunkValid} !== {2'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_setup got idx=%0d vld=%b exp idx=2 vld=1", bus.chunkIdx, bus.chunkValid);
        end
        #2 rst = 1'b0;
        #1;
        m_n = 1'b0; m_z = 1'b0;
        tests_run++;
        if ({bus.chunkValid, bus.done, bus.busy, bus.flagN, bus.flagZ, bus.chunkIdx, bus.reqReady, bus.pcWrEnOut}
            !== {5'b00000, 2'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_async got vld=%b done=%b busy=%b n=%b z=%b idx=%0d rdy=%b pc=%b exp all 0 rdy=1",
                     bus.chunkValid, bus.done, bus.busy, bus.flagN, bus.flagZ, bus.chunkIdx, bus.reqReady, bus.pcWrEnOut);
        end
        pulses = 0;
        repeat (2) begin @(negedge clk); if (bus.done !== 1'b0) pulses++; end
        rst = 1'b1;
        repeat (6) begin @(negedge clk); if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++; end
        tests_run++;
        if (pulses != 0 || {bus.flagN, bus.flagZ, bus.reqReady} !== {m_n, m_z, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_no_done got pulses=%0d n=%b z=%b rdy=%b exp pulses=0 n=0 z=0 rdy=1",
                     pulses, bus.flagN, bus.flagZ, bus.reqReady);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] op, br;
        logic sf;
        for (int it = 0; it < 30; it++) begin
            op = 3'($urandom);
            br = 3'($urandom);
            sf = 1'($urandom);
            for (int k = 0; k < NCH; k++) begin
                neg_v[k]  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
                zero_v[k] = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom);
            end
            drive_op(op, br, sf);
            model_op(br, sf);
            tests_run++;
            if ({o_done, o_n, o_z, o_pc, o_done2} !== {1'b1, m_n, m_z, m_pc, 1'b0}) begin
                tests_failed++;
                $display("FAIL rand%0d_result br=%b sf=%b got done=%b n=%b z=%b pc=%b done_next=%b exp 1 %b %b %b 0",
                         it, br, sf, o_done, o_n, o_z, o_pc, o_done2, m_n, m_z, m_pc);
            end
            for (int k = 0; k < NCH; k++) begin
                tests_run++;
                if ({o_idx[k], o_vld[k], o_op[k]} !== {2'(k), 1'b1, op}) begin
                    tests_failed++;
                    $display("FAIL rand%0d_chunk%0d got idx=%0d vld=%b op=%b exp idx=%0d vld=1 op=%b",
                             it, k, o_idx[k], o_vld[k], o_op[k], k, op);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_branch();
        test_nz_branch();
        test_hold_flags();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Controller for the SIMD execute stage. It accepts one vector operation per request and sequences it through a shared array of `laneCount` ALU lanes, one chunk of `laneCount` elements per cycle, until all `vecSize` elements are processed. It accumulates the per-lane negative/zero flags across chunks, updates the architectural N/Z flag registers, and resolves the branch condition. It sits between decode, which issues requests, and the lane ALU array plus writeback, which consume the chunk strobes.

## Interface
Parameters:
- `regSize`, 16, element width; forwarded for consistency and unused internally.
- `vecSize`, 8, elements per vector.
- `laneCount`, 2, physical ALU lanes. `vecSize % laneCount` must be 0; elaboration fails otherwise.
- Derived: `numChunks = vecSize/laneCount` and `idxW = max(1, $clog2(numChunks))`.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  decode presents an operation.
- `reqReady`  out  1  sequencer can accept an operation.
- `reqOp`  in  3  ALU operation select.
- `reqBranch`  in  3  branch code: 100 = taken if !Z, 010 = taken if Z, 001 = taken if N, anything else = not taken.
- `reqSetFlags`  in  1  the operation overwrites N/Z.
- `aluOp`  out  3  latched operation select driven to all lanes.
- `chunkIdx`  out  idxW  chunk currently on the lanes; selects elements `[chunkIdx*laneCount +: laneCount]`.
- `chunkValid`  out  1  lanes hold valid operands; writeback stores the lane results.
- `laneNeg`  in  laneCount  per-lane negative flag for the current chunk (combinational from the ALUs).
- `laneZero`  in  laneCount  per-lane zero flag for the current chunk.
- `done`  out  1  one-cycle completion pulse.
- `pcWrEnOut`  out  1  branch-taken result; meaningful only while `done`=1, and 0 otherwise.
- `flagN`, `flagZ`  out  1 each  architectural flags.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- `reqReady` = (state==IDLE) or (state==DONE).
- A request is accepted when `reqValid & reqReady`.
- On accept, the sequencer latches `reqOp`, `reqBranch` and `reqSetFlags`, sets `chunkIdx`=0, initialises the accumulators (negAcc=0, zeroAcc=1), and goes to RUN.
- In RUN:
  - `chunkValid`=1.
  - Each cycle, negAcc |= |laneNeg and zeroAcc &= &laneZero. Only lanes of the current chunk are sampled.
  - If `chunkIdx`==numChunks-1: go to DONE. If the latched setFlags is 1, load flagN←final negAcc and flagZ←final zeroAcc, where the final values include this cycle's lanes.
  - Otherwise: `chunkIdx`++.
- In DONE:
  - `done`=1.
  - `pcWrEnOut` is evaluated from `flagN`/`flagZ` as visible in this cycle. These are the new flags if setFlags was 1, otherwise the held flags.
  - The next state is RUN if a new request is accepted, otherwise IDLE.
- Multi-hot or zero branch codes give `pcWrEnOut`=0.
- `aluOp` holds its last latched value in IDLE and DONE.
- `reqOp` and `reqBranch` are ignored whenever the sequencer is not accepting.

## Timing
- Reset values: state=IDLE, `reqReady`=1, `aluOp`=0, `chunkIdx`=0, `chunkValid`=0, `done`=0, `pcWrEnOut`=0, `flagN`=0, `flagZ`=0, `busy`=0.
- Latency for a request accepted at edge t0:
  - chunk k is on the lanes in cycle t0+1+k;
  - `done` is asserted in cycle t0+1+numChunks.
- Throughput: a request held valid during DONE is accepted, giving one operation every numChunks+1 cycles.
- numChunks=1: RUN lasts exactly one cycle.
- `chunkIdx` never exceeds numChunks-1; there is no wrap beyond the final chunk.
- Reset during RUN or DONE:
  - the operation is aborted immediately and asynchronously;
  - `chunkValid` and `done` drop without waiting for a clock edge;
  - flags clear;
  - no partial flag update survives.

## Structure
- Package `simd_ctrl_pkg`:
  - state enum `seq_state_t` (IDLE, RUN, DONE);
  - branch code constants `BR_NZ`=3'b100, `BR_Z`=3'b010, `BR_N`=3'b001.
- Sub-module `nz_flag_accum` contains:
  - the negAcc/zeroAcc registers;
  - the clear-on-accept and per-chunk reduction logic;
  - the architectural flag registers with their load enable.
- The FSM, chunk counter and branch resolve live in `exec_sequencer`.

## Test plan
All scenarios use vecSize=8 and laneCount=2 (numChunks=4).
- Reset: assert `rst`=0 mid-stream → all outputs take their reset values at once; `reqReady`=1 after release.
- Accept op=3'b011, branch=010, setFlags=1, `laneZero`=2'b11 every chunk → `chunkIdx` 0,1,2,3 in cycles 1–4; `done` in cycle 5; `flagZ`=1; `pcWrEnOut`=1.
- Same request with `laneZero`=2'b01 at chunk 2 and branch=100 → `flagZ`=0 and `pcWrEnOut`=1. Repeat with branch=010 → `pcWrEnOut`=0.
- Prior state flagN=1; request with setFlags=0, `laneNeg`=0 throughout, branch=001 → flags unchanged and `pcWrEnOut`=1.
- `reqValid` held continuously → `reqReady`=0 during RUN, the second request is accepted in the DONE cycle, and `chunkIdx`=0 with `chunkValid`=1 in the following cycle.
- `rst` asserted at chunk 2 with setFlags=1 → `chunkValid`=0 immediately, flags stay 0, and no `done` pulse occurs.
